sr_cmd_gen: RTL and testbench

Command front end for the sr_ff set/reset flip-flop. It takes two raw, asynchronous, bouncy request levels (set and clear) and synchronizes and debounces them. Each filtered rising edge becomes a single-cycle registered `s` or `r` pulse that drives the flip-flop's inputs directly. The block guarantees that `s` and `r` are never high together, so the flip-flop's illegal S=R=1 condition cannot occur, and it spaces commands by a guard interval.

---
 rtl/sr_cmd_gen.sv | 183 ++++++++++++++++++
 tb/tb_sr_cmd_gen.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen: command front end for an sr_ff set/reset flip-flop.
//
// Two raw request levels (set_in, clr_in) are optionally synchronized and then
// debounced. Every filtered rising edge becomes one registered single-cycle
// pulse on s or r. s and r are never high together. Clear wins over set when
// both are requested at once. Consecutive pulses are separated by a guard
// interval.
//
// Build option:
//   SR_CMD_SYNC_EN  defined   -> 2-flop synchronizer on each input
//                   undefined -> inputs feed the debouncers directly; use this
//                                only when the inputs are already synchronous
//                                to clk. Latency is 2 cycles shorter.
//
// Parameters:
//   DB_CYCLES     consecutive stable samples to accept a level change (1..255)
//   GUARD_CYCLES  idle cycles after each s/r pulse (1..255)
//
// Ports:
//   clk      clock; all state changes on the rising edge
//   reset_n  asynchronous active-low reset
//   set_in   raw set request level
//   clr_in   raw clear request level
//   s        one-cycle set pulse to the flip-flop
//   r        one-cycle reset pulse to the flip-flop
//   busy     high in SET, CLR or GUARD
//   ovf      sticky: a request was dropped because the same one was pending
module sr_cmd_gen #(
    parameter int unsigned DB_CYCLES    = 4,
    parameter int unsigned GUARD_CYCLES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic set_in,
    input  logic clr_in,
    output logic s,
    output logic r,
    output logic busy,
    output logic ovf
);

    localparam logic [7:0] DbLast    = 8'(DB_CYCLES - 1);
    localparam logic [7:0] GuardLast = 8'(GUARD_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StSet, StClr, StGuard} state_e;

    // Channel index 0 is set, index 1 is clear.
    logic [1:0]      raw;
    logic [1:0]      sync;
    logic [1:0]      flt_q, flt_d;
    logic [1:0]      flt_dly_q;
    logic [1:0][7:0] db_cnt_q, db_cnt_d;
    logic [1:0]      req;

    state_e     state_q, state_d;
    logic [7:0] guard_cnt_q, guard_cnt_d;
    logic       pend_s_q, pend_s_d;
    logic       pend_c_q, pend_c_d;
    logic       ovf_q, ovf_d;
    logic       s_q, s_d;
    logic       r_q, r_d;
    logic       busy_q, busy_d;

    assign raw = {clr_in, set_in};

`ifdef SR_CMD_SYNC_EN
    logic [1:0] meta_q;
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= 2'b00;
            sync_q <= 2'b00;
        end else begin
            meta_q <= raw;
            sync_q <= meta_q;
        end
    end

    assign sync = sync_q;
`else
    assign sync = raw;
`endif

    // Debounce: a level change is accepted only after DB_CYCLES consecutive
    // samples that differ from the current filtered level.
    always_comb begin
        flt_d    = flt_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync[i] != flt_q[i]) begin
                if (db_cnt_q[i] == DbLast) begin
                    flt_d[i]    = sync[i];
                    db_cnt_d[i] = 8'd0;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 8'd1;
                end
            end else begin
                db_cnt_d[i] = 8'd0;
            end
        end
    end

    // Only rising edges of the filtered level are requests.
    assign req = flt_q & ~flt_dly_q;

    always_comb begin
        state_d     = state_q;
        guard_cnt_d = guard_cnt_q;
        pend_s_d    = pend_s_q;
        pend_c_d    = pend_c_q;

        // Any edge is remembered; it is consumed below if served this cycle.
        if (req[0]) pend_s_d = 1'b1;
        if (req[1]) pend_c_d = 1'b1;

        unique case (state_q)
            StIdle: begin
                if (req[1] || pend_c_q) begin
                    state_d  = StClr;
                    pend_c_d = 1'b0;
                end else if (req[0] || pend_s_q) begin
                    state_d  = StSet;
                    pend_s_d = 1'b0;
                end
            end
            StSet, StClr: begin
                state_d     = StGuard;
                guard_cnt_d = 8'd0;
            end
            StGuard: begin
                if (guard_cnt_q == GuardLast) begin
                    state_d = StIdle;
                end else begin
                    guard_cnt_d = guard_cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // An edge on a channel that already has a pending request is lost.
        ovf_d = ovf_q | (req[0] & pend_s_q) | (req[1] & pend_c_q);

        // Outputs are registered from the next state so they align with it.
        s_d    = (state_d == StSet);
        r_d    = (state_d == StClr);
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flt_q       <= 2'b00;
            flt_dly_q   <= 2'b00;
            db_cnt_q    <= '0;
            state_q     <= StIdle;
            guard_cnt_q <= 8'd0;
            pend_s_q    <= 1'b0;
            pend_c_q    <= 1'b0;
            ovf_q       <= 1'b0;
            s_q         <= 1'b0;
            r_q         <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            flt_q       <= flt_d;
            flt_dly_q   <= flt_q;
            db_cnt_q    <= db_cnt_d;
            state_q     <= state_d;
            guard_cnt_q <= guard_cnt_d;
            pend_s_q    <= pend_s_d;
            pend_c_q    <= pend_c_d;
            ovf_q       <= ovf_d;
            s_q         <= s_d;
            r_q         <= r_d;
            busy_q      <= busy_d;
        end
    end

    assign s    = s_q;
    assign r    = r_q;
    assign busy = busy_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Directed testbench for sr_cmd_gen. Instance a uses default parameters;
// instance b uses a long guard interval so that a second set edge can arrive
// while the first one is still pending (overflow case).
module tb_sr_cmd_gen;

    localparam int DbCycles = 4;
`ifdef SR_CMD_SYNC_EN
    localparam int SyncLat = 2;
`else
    localparam int SyncLat = 0;
`endif
    // Edge after which the pulse is visible, counting from the first edge
    // that samples the raised input.
    localparam int Lat = DbCycles + 1 + SyncLat;

    logic clk;
    logic a_rst_n, a_set, a_clr, a_s, a_r, a_busy, a_ovf;
    logic b_rst_n, b_set, b_clr, b_s, b_r, b_busy, b_ovf;
    logic ff_q;

    int n_checks;
    int n_fail;
    int cnt_bs;
    int cnt_br;
    int both_b;

    sr_cmd_gen #(
        .DB_CYCLES    (DbCycles),
        .GUARD_CYCLES (2)
    ) dut_a (
        .clk     (clk),
        .reset_n (a_rst_n),
        .set_in  (a_set),
        .clr_in  (a_clr),
        .s       (a_s),
        .r       (a_r),
        .busy    (a_busy),
        .ovf     (a_ovf)
    );

    sr_cmd_gen #(
        .DB_CYCLES    (DbCycles),
        .GUARD_CYCLES (30)
    ) dut_b (
        .clk     (clk),
        .reset_n (b_rst_n),
        .set_in  (b_set),
        .clr_in  (b_clr),
        .s       (b_s),
        .r       (b_r),
        .busy    (b_busy),
        .ovf     (b_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural sr_ff driven by instance a.
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n)  ff_q <= 1'b0;
        else if (a_s)  ff_q <= 1'b1;
        else if (a_r)  ff_q <= 1'b0;
    end

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Clock instance b while tallying its pulses.
    task automatic bcyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (b_s === 1'b1) cnt_bs++;
            if (b_r === 1'b1) cnt_br++;
            if ((b_s & b_r) === 1'b1) both_b++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cnt_bs   = 0;
        cnt_br   = 0;
        both_b   = 0;
        a_rst_n  = 1'b0;
        b_rst_n  = 1'b0;
        a_set    = 1'b0;
        a_clr    = 1'b0;
        b_set    = 1'b0;
        b_clr    = 1'b0;

        // Reset values.
        #12;
        check("rst_s",    a_s,    1'b0);
        check("rst_r",    a_r,    1'b0);
        check("rst_busy", a_busy, 1'b0);
        check("rst_ovf",  a_ovf,  1'b0);
        cyc(1);
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        cyc(3);

        // Clean set: single s pulse after edge Lat, busy through SET and GUARD.
        a_set = 1'b1;
        for (int k = 1; k <= Lat + 6; k++) begin
            cyc(1);
            check("set_s", a_s, k == Lat);
            check("set_r", a_r, 1'b0);
            if (k == Lat - 1 || k == Lat + 4) check("set_busy_lo", a_busy, 1'b0);
            if (k >= Lat && k <= Lat + 2)     check("set_busy_hi", a_busy, 1'b1);
        end
        check("set_ff", ff_q, 1'b1);
        a_set = 1'b0;
        cyc(10);
        check("set_ovf", a_ovf, 1'b0);

        // Glitch of 3 cycles is filtered out.
        a_set = 1'b1;
        cyc(3);
        a_set = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            cyc(1);
            check("glitch_quiet", a_s | a_r | a_busy, 1'b0);
        end

        // Simultaneous set and clear: r first, s four cycles later.
        a_set = 1'b1;
        a_clr = 1'b1;
        for (int k = 1; k <= Lat + 8; k++) begin
            cyc(1);
            check("both_r",  a_r, k == Lat);
            check("both_s",  a_s, k == Lat + 4);
            check("both_sr", a_s & a_r, 1'b0);
        end
        check("both_ovf", a_ovf, 1'b0);
        check("both_ff",  ff_q,  1'b1);
        a_set = 1'b0;
        a_clr = 1'b0;
        cyc(10);

        // Clear alone; chained flip-flop drops on the edge that samples r.
        a_clr = 1'b1;
        for (int k = 1; k <= Lat + 3; k++) begin
            cyc(1);
            check("clr_r", a_r, k == Lat);
            check("clr_s", a_s, 1'b0);
            if (k == Lat + 1) check("clr_ff", ff_q, 1'b0);
        end
        a_clr = 1'b0;
        cyc(10);

        // Reset during the r pulse with a set pending: everything drops at once.
        a_set = 1'b1;
        a_clr = 1'b1;
        cyc(Lat);
        check("mid_r_pre",    a_r, 1'b1);
        check("mid_pend_pre", dut_a.pend_s_q, 1'b1);
        #1;
        a_rst_n = 1'b0;
        #1;
        check("mid_r",      a_r,    1'b0);
        check("mid_busy",   a_busy, 1'b0);
        check("mid_pend_s", dut_a.pend_s_q, 1'b0);
        check("mid_pend_c", dut_a.pend_c_q, 1'b0);
        a_set = 1'b0;
        a_clr = 1'b0;
        cyc(2);
        a_rst_n = 1'b1;
        for (int k = 1; k <= Lat + 8; k++) begin
            cyc(1);
            check("post_rst_quiet", a_s | a_r | a_busy, 1'b0);
        end
        a_set = 1'b1;
        for (int k = 1; k <= Lat + 2; k++) begin
            cyc(1);
            check("post_rst_s", a_s, k == Lat);
        end
        a_set = 1'b0;
        cyc(10);

        // Overflow on instance b: second set edge while the first is pending.
        b_clr = 1'b1;
        bcyc(Lat + 3);
        b_set = 1'b1;
        bcyc(6);
        b_set = 1'b0;
        bcyc(8);
        check("ovf_before", b_ovf, 1'b0);
        b_set = 1'b1;
        bcyc(40);
        check("ovf_set",   b_ovf, 1'b1);
        b_set = 1'b0;
        b_clr = 1'b0;
        bcyc(12);
        check("ovf_sticky", b_ovf, 1'b1);
        check_int("ovf_s_count", cnt_bs, 1);
        check_int("ovf_r_count", cnt_br, 1);
        check_int("ovf_sr_both", both_b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
